// File: rtl/dmem_pkg.sv
// Shared types, widths and the request error check for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned byte address, or word index beyond the end of the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the memory stage and the responder.
interface dmem_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [WORD_W-1:0]    req_wdata;
  logic [NUM_LANES-1:0] req_be;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_W-1:0]    rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-addressed storage split into byte lanes; shared address, registered read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NUM_LANES-1:0] be,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic                 re,
  output logic [WORD_W-1:0]    rd_data
);

  // One memory per byte lane; the read register only updates on re so it holds a response.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH_WORDS];
    logic [BYTE_W-1:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[addr] <= wdata[gi*BYTE_W +: BYTE_W];
      end
      if (re) begin
        lane_rd_q <= lane_mem[addr];
      end
    end

    assign rd_data[gi*BYTE_W +: BYTE_W] = lane_rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              load_q, load_d;
  logic              accept;
  logic              req_err;
  logic [WORD_W-1:0] rd_data;

  assign req_err = addr_err(bus.req_addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          err_d   = req_err;
          load_d  = !bus.req_we;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Errored requests touch neither the array contents nor the returned data.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we      (accept && bus.req_we && !req_err),
    .be      (bus.req_be),
    .addr    (bus.req_addr[AW+1:2]),
    .wdata   (bus.req_wdata),
    .re      (accept && !bus.req_we),
    .rd_data (rd_data)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = (bus.rsp_valid && load_q && !err_q) ? rd_data : '0;

endmodule
